// File: rtl/mznm_pkg.sv
// Shared definitions for the instruction-fetch block.
// Contents:
//   PC_W_DEF / INSTR_W_DEF  default address and instruction widths
//   RESET_PC_DEF            default first fetch address after reset
//   PC_STEP_DEF             default address increment per instruction
//   fetch_state_e           fetch controller states {IDLE, FETCH, FLUSH}
package mznm_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam int          INSTR_W_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_slot_fifo.sv
// In-order slot storage for the fetch queue.
// A slot is allocated when a fetch request is accepted (tagged with its PC),
// filled when the matching memory response returns, and read out in order.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   flush             drop every slot and rewind all pointers (wins over all)
//   alloc, alloc_pc   allocate the next slot with this PC
//   fill, fill_instr  fill the oldest unfilled slot
//   pop               release the head slot
//   head_valid        head slot allocated and filled
//   head_pc/instr     head slot contents
//   occupancy         allocated, not yet popped slots (filled + in flight)
//   inflight          allocated, not yet filled slots
module fetch_slot_fifo #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [PC_W-1:0]            alloc_pc,
  input  logic                       fill,
  input  logic [INSTR_W-1:0]         fill_instr,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [PC_W-1:0]            head_pc,
  output logic [INSTR_W-1:0]         head_instr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0]      alloc_ptr_q, alloc_ptr_d;
  logic [CW-1:0]      fill_ptr_q,  fill_ptr_d;
  logic [CW-1:0]      rd_ptr_q,    rd_ptr_d;
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [PC_W-1:0]    pc_d    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];
  logic [DEPTH-1:0]   filled_q, filled_d;

  logic [AW-1:0] alloc_idx, fill_idx, rd_idx;

  assign alloc_idx = alloc_ptr_q[AW-1:0];
  assign fill_idx  = fill_ptr_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      filled_d    = '0;
    end else begin
      if (alloc) begin
        pc_d[alloc_idx] = alloc_pc;
        alloc_ptr_d     = alloc_ptr_q + CW'(1);
      end
      // fill and pop always address different slots: fill targets an
      // unfilled slot, pop a filled one.
      if (fill) begin
        instr_d[fill_idx]  = fill_instr;
        filled_d[fill_idx] = 1'b1;
        fill_ptr_d         = fill_ptr_q + CW'(1);
      end
      if (pop) begin
        filled_d[rd_idx] = 1'b0;
        rd_ptr_d         = rd_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      filled_q    <= filled_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
    end
  end

  assign head_valid = filled_q[rd_idx];
  assign head_pc    = pc_q[rd_idx];
  assign head_instr = instr_q[rd_idx];
  assign occupancy  = alloc_ptr_q - rd_ptr_q;
  assign inflight   = alloc_ptr_q - fill_ptr_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch stage: generates fetch addresses, issues requests to
// instruction memory, queues returned words with their PC and hands
// {instr, pc} to decode over valid/ready. A redirect flushes the queue and
// drops memory responses that were already in flight.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   imem_req_valid/ready/addr  fetch request channel
//   imem_rsp_valid/data        in-order response channel, never stalled
//   redirect, redirect_pc      flush and retarget fetch
//   dec_valid/ready            head entry handshake to decode
//   dec_instr, dec_pc          head entry contents
//   perf_fetched, perf_stall   (FETCH_PERF_CNT_EN only) delivered instrs,
//                              cycles decode was ready but starved
//
// state | meaning
// IDLE  | one cycle after reset, no requests
// FETCH | normal fetch; responses fill the queue
// FLUSH | no requests; stale responses are counted down and discarded
module instr_fetch_queue
  import mznm_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
`endif
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic          req_accept;
  logic          dec_pop;
  logic          fifo_fill;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;

  // Occupancy counts in-flight requests too, so a request is only raised
  // when its response is guaranteed a slot. Both terms are registered, so
  // once raised the request can only drop on acceptance or redirect.
  assign imem_req_valid = (state_q == FETCH) && (occupancy < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign dec_pop        = dec_valid && dec_ready;
  // Responses only reach the queue in FETCH; in FLUSH they are stale.
  assign fifo_fill      = imem_rsp_valid && (state_q == FETCH) && !redirect;

  fetch_slot_fifo #(
    .DEPTH   (DEPTH),
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_slots (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .alloc      (req_accept),
    .alloc_pc   (fetch_pc_q),
    .fill       (fifo_fill),
    .fill_instr (imem_rsp_data),
    .pop        (dec_pop),
    .head_valid (dec_valid),
    .head_pc    (dec_pc),
    .head_instr (dec_instr),
    .occupancy  (occupancy),
    .inflight   (inflight)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (req_accept) begin
      fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
    end
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          // A request accepted this cycle is already stale; a response
          // arriving this cycle is discarded here and needs no drop.
          drop_cnt_d = inflight + CW'(req_accept) - CW'(imem_rsp_valid);
          if (drop_cnt_d != '0) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (imem_rsp_valid && (drop_cnt_q != '0)) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (drop_cnt_q == '0) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Not touched by redirect: a handshake on a redirect cycle still counts.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (dec_pop) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (dec_ready && !dec_valid) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  // Reference model: requests outstanding at memory (live or stale) and
  // returned words waiting for decode, each visible from a given cycle.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          t;
    bit          live;
  } fl_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          vis;
  } rd_t;

  fl_t         infl[$];
  rd_t         rdyq[$];
  int          cyc = 0;
  int          quiet = 0;   // consecutive cycle starts with no stale response pending
  int          dead = 0;    // stale responses still to come back
  logic [31:0] fetch_pc_m = 32'h0;
  logic [31:0] m_fetched = 32'h0;
  logic [31:0] m_stall = 32'h0;
  logic [23:0] seq = 24'h0;
  int          mem_lat = 1;
  int          mem_p = 100;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit dv_now();
    return (rdyq.size() > 0) && (rdyq[0].vis <= cyc);
  endfunction

  function automatic bit rsp_due();
    return reset && (infl.size() > 0) && (cyc >= infl[0].t + mem_lat);
  endfunction

  task automatic model_reset();
    infl.delete();
    rdyq.delete();
    quiet      = 0;
    dead       = 0;
    fetch_pc_m = 32'h0;
    m_fetched  = 32'h0;
    m_stall    = 32'h0;
  endtask

  // One clock: memory drives its response, outputs are checked against the
  // model, the model advances, then the edge passes.
  task automatic cycle();
    bit          exp_rv, exp_dv, acc, pop;
    int          live_n;
    fl_t         f;
    rd_t         r;
    logic [31:0] rnd;
    if (rsp_due() && ($urandom_range(99) < mem_p)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = infl[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    if (reset) begin
      quiet  = (dead == 0) ? ((quiet < 3) ? quiet + 1 : 3) : 0;
      live_n = 0;
      foreach (infl[i]) if (infl[i].live) live_n++;
      exp_rv = (quiet >= 2) && ((live_n + rdyq.size()) < DEPTH);
      exp_dv = dv_now();
      check("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check("req_addr", imem_req_addr, fetch_pc_m);
      check("dec_valid", dec_valid, exp_dv);
      if (exp_dv) begin
        check("dec_pc", dec_pc, rdyq[0].pc);
        check("dec_instr", dec_instr, rdyq[0].data);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall", perf_stall, m_stall);
`endif
      acc = exp_rv && imem_req_ready;
      pop = exp_dv && dec_ready;
      if (pop) begin
        void'(rdyq.pop_front());
        m_fetched++;
      end
      if (dec_ready && !exp_dv) m_stall++;
      if (imem_rsp_valid) begin
        f = infl.pop_front();
        if (!f.live) dead--;
        else if (!redirect) begin
          r.pc = f.pc; r.data = f.data; r.vis = cyc + 1;
          rdyq.push_back(r);
        end
      end
      if (acc) begin
        rnd    = $urandom;
        f.pc   = fetch_pc_m;
        f.data = {rnd[7:0], seq};
        f.t    = cyc;
        f.live = 1'b1;
        infl.push_back(f);
        fetch_pc_m = fetch_pc_m + 32'd2;
        seq++;
      end
      if (redirect) begin
        rdyq.delete();
        foreach (infl[i]) if (infl[i].live) begin
          infl[i].live = 1'b0;
          dead++;
        end
        fetch_pc_m = redirect_pc;
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit hit;
    bit saw0;
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    repeat (3) cycle();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_addr", imem_req_addr, 32'h0);
    check("rst_dec_valid", dec_valid, 1'b0);

    // Fill to capacity with decode stalled, then free one slot.
    reset = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b0;
    repeat (8) cycle();
    check("full_req_valid", imem_req_valid, 1'b0);
    check("full_addr", imem_req_addr, 32'h8);
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    check("refill_req_valid", imem_req_valid, 1'b1);
    check("refill_addr", imem_req_addr, 32'h8);
    cycle();

    // Memory not ready: request held with a stable address.
    imem_req_ready = 1'b0; dec_ready = 1'b1;
    repeat (2) cycle();
    dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_req_valid", imem_req_valid, 1'b1);
      check("stall_addr", imem_req_addr, 32'hA);
      cycle();
    end

    // Redirect with two requests in flight.
    dec_ready = 1'b1;
    repeat (6) cycle();
    mem_lat = 4; imem_req_ready = 1'b1;
    repeat (2) cycle();
    imem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0; imem_req_ready = 1'b1;
    check("flush_req_valid", imem_req_valid, 1'b0);
    for (int k = 0; k < 30 && dec_valid !== 1'b1; k++) cycle();
    check("redir_dec_valid", dec_valid, 1'b1);
    check("redir_first_pc", dec_pc, 32'h100);
    mem_lat = 1;

    // Redirect on the same cycle as a live response and a decode handshake.
    for (int k = 0; k < 50 && !(dv_now() && rsp_due() && infl[0].live); k++) cycle();
    hit = dv_now() && rsp_due() && infl[0].live;
    check("same_cycle_hit", hit, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h400;
    cycle();
    redirect = 1'b0;
    check("same_cycle_dec_valid", dec_valid, 1'b0);
    repeat (12) cycle();

    // Address wrap.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    redirect = 1'b0;
    saw0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req_valid && imem_req_ready && fetch_pc_m == 32'h0) saw0 = 1'b1;
      cycle();
    end
    check("wrap_to_zero", saw0, 1'b1);

    // Reset in the middle of traffic.
    reset = 1'b0;
    cycle();
    check("midrst_req_valid", imem_req_valid, 1'b0);
    check("midrst_addr", imem_req_addr, 32'h0);
    check("midrst_dec_valid", dec_valid, 1'b0);
    check("midrst_dec_instr", dec_instr, 32'h0);
    check("midrst_dec_pc", dec_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("midrst_perf_fetched", perf_fetched, 32'h0);
    check("midrst_perf_stall", perf_stall, 32'h0);
`endif
    reset = 1'b1;
    repeat (10) cycle();

    // Randomized traffic in blocks with different pressures.
    for (int b = 0; b < 6; b++) begin
      int p_rdy, p_dec, p_red;
      p_rdy   = $urandom_range(100, 20);
      p_dec   = $urandom_range(100, 10);
      p_red   = $urandom_range(6, 1);
      mem_lat = $urandom_range(3, 1);
      mem_p   = $urandom_range(100, 40);
      for (int k = 0; k < 500; k++) begin
        imem_req_ready = ($urandom_range(99) < p_rdy);
        dec_ready      = ($urandom_range(99) < p_dec);
        redirect       = ($urandom_range(99) < p_red);
        redirect_pc    = $urandom;
        reset          = !($urandom_range(999) < 2);
        cycle();
      end
    end
    reset = 1'b1; redirect = 1'b0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
